// File: rtl/sram_req_arbiter_pkg.sv
// Shared definitions for the SRAM-like request arbiter slice.
package sram_req_arbiter_pkg;

    // Source id carried in each tag FIFO entry.
    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } src_t;

    // SRAM-like access size encodings.
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/sram_req_arbiter_tag_fifo.sv
// In-order FIFO of source ids, one entry per accepted-but-unanswered request.
module tag_fifo
    import sram_req_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  src_t                     push_src,
    input  logic                     pop,
    output src_t                     head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    src_t            mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage write; entries need no reset since count gates their use.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_src;
        end
    end

    // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// Merges inst and data SRAM-like ports onto one bridge port, with data
// priority, a starvation guard, grant lock during address handshakes and
// in-order response routing.
module sram_req_arbiter
    import sram_req_arbiter_pkg::*;
#(
    parameter int unsigned OUTSTANDING_DEPTH = 4,
    parameter int unsigned STARVE_LIMIT      = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        out_req,
    output logic        out_wr,
    output logic [1:0]  out_size,
    output logic [3:0]  out_wstrb,
    output logic [31:0] out_addr,
    output logic [31:0] out_wdata,
    input  logic        out_addr_ok,
    input  logic        out_data_ok,
    input  logic [31:0] out_rdata,

    output logic        busy,
    output logic        err_unexpected
);

    localparam int unsigned CW  = $clog2(OUTSTANDING_DEPTH) + 1;
    localparam int unsigned SCW = $clog2(STARVE_LIMIT + 1);

    src_t           sel;
    src_t           lock_src;
    src_t           head_src;
    logic           lock;
    logic [SCW-1:0] starve_cnt;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic           accept;
    logic           resp_valid;
    logic           unexpected;

    // Grant selection: locked source wins, then data unless inst is starving.
    always_comb begin
        sel = SRC_INST;
        if (lock) begin
            sel = lock_src;
        end else if (data_req && inst_req) begin
            sel = (starve_cnt == SCW'(STARVE_LIMIT)) ? SRC_INST : SRC_DATA;
        end else if (data_req) begin
            sel = SRC_DATA;
        end
    end

    // Request fields follow the granted source with no added latency.
    always_comb begin
        out_req = !rst && !fifo_full && (lock || inst_req || data_req);
        if (sel == SRC_DATA) begin
            out_wr    = data_wr;
            out_size  = data_size;
            out_wstrb = data_wstrb;
            out_addr  = data_addr;
            out_wdata = data_wdata;
        end else begin
            out_wr    = inst_wr;
            out_size  = inst_size;
            out_wstrb = inst_wstrb;
            out_addr  = inst_addr;
            out_wdata = inst_wdata;
        end
    end

    assign accept       = out_req && out_addr_ok;
    assign inst_addr_ok = accept && (sel == SRC_INST);
    assign data_addr_ok = accept && (sel == SRC_DATA);

    assign resp_valid   = !rst && out_data_ok && !fifo_empty;
    assign unexpected   = out_data_ok && fifo_empty;
    assign inst_data_ok = resp_valid && (head_src == SRC_INST);
    assign data_data_ok = resp_valid && (head_src == SRC_DATA);
    assign inst_rdata   = out_rdata;
    assign data_rdata   = out_rdata;
    assign busy         = !rst && (fifo_count != '0);

    // Lock, starvation counter and sticky error tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock           <= 1'b0;
            lock_src       <= SRC_INST;
            starve_cnt     <= '0;
            err_unexpected <= 1'b0;
        end else begin
            if (out_addr_ok) begin
                lock <= 1'b0;
            end else if (out_req) begin
                lock     <= 1'b1;
                lock_src <= sel;
            end

            if (accept && (sel == SRC_DATA) && inst_req) begin
                if (starve_cnt != SCW'(STARVE_LIMIT)) begin
                    starve_cnt <= starve_cnt + SCW'(1);
                end
            end else if ((accept && (sel == SRC_INST)) || !inst_req) begin
                starve_cnt <= '0;
            end

            if (unexpected) begin
                err_unexpected <= 1'b1;
            end
        end
    end

    tag_fifo #(
        .DEPTH(OUTSTANDING_DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (accept),
        .push_src (sel),
        .pop      (out_data_ok),
        .head     (head_src),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

endmodule
